// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - requester <-> serial adder handshake/data bundle
//
// Purpose: groups the start/busy/done handshake, operands and result of
//          serial_add_ctrl so requester and adder connect through one port.
// Signals:
//   start  requester -> adder  request; sampled only while the adder is idle
//   a, b   requester -> adder  WIDTH-bit operands, captured on accepted start
//   cin    requester -> adder  carry-in, captured on accepted start
//   busy   adder -> requester  high while bits are being computed
//   done   adder -> requester  one-cycle pulse, result valid
//   sum    adder -> requester  registered WIDTH-bit result
//   cout   adder -> requester  registered carry-out
//   ovf    adder -> requester  signed overflow (only with SERIAL_ADD_OVERFLOW_EN)
// Modports: master = requester side, slave = adder side.
// Build option: SERIAL_ADD_OVERFLOW_EN adds ovf.

interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVERFLOW_EN
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller around one full-adder cell
//
// Purpose: computes {cout,sum} = a + b + cin one bit per clock, LSB first,
//          using a single 1-bit full_adder cell. Operands are captured on an
//          accepted start, the carry is held between bits, and the result is
//          assembled in a shift register and published on entry to DONE.
// Ports:
//   clk    input   rising-edge clock
//   rst    input   synchronous, active-high reset
//   bus    slave   serial_add_ctrl_if (start/a/b/cin in; busy/done/sum/cout out)
// Timing: start accepted at edge 0, busy in cycles 1..WIDTH, done in WIDTH+1.
// Build option: SERIAL_ADD_OVERFLOW_EN adds registered signed-overflow ovf.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  serial_add_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  // Only WIDTH-1 earlier bits need storage; the last bit comes straight
  // from the cell when the result is published.
  logic [WIDTH-2:0] r_res;
  logic [WIDTH-2:0] w_res_next;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
`ifdef SERIAL_ADD_OVERFLOW_EN
  logic             r_ovf;
`endif

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic             w_busy;
  logic             w_done;

  full_adder u_fa (
    .i_a (r_a[0]),
    .i_b (r_b[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_res_next             = r_res >> 1;
    w_res_next[WIDTH-2]    = w_s;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_next = ST_IDLE;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next = bus.start ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        w_busy = 1'b1;
        w_next = w_last ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        // start is deliberately ignored here; nothing is queued
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        // illegal encoding recovers to IDLE
        w_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: operand shift regs, carry, bit counter, result assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef SERIAL_ADD_OVERFLOW_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_c;
          r_res   <= w_res_next;
          if (w_last) begin
            // sum/cout only ever change here, so they hold while busy
            r_sum  <= {w_s, r_res};
            r_cout <= w_c;
`ifdef SERIAL_ADD_OVERFLOW_EN
            // r_carry is the carry into the MSB during this last bit
            r_ovf  <= r_carry ^ w_c;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
`ifdef SERIAL_ADD_OVERFLOW_EN
  assign bus.ovf  = r_ovf;
`endif

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: one 1-bit full_adder cell computes a WIDTH-bit sum, one bit per clock, LSB first.
- Registers the operands, sequences the shared cell, holds the carry between bits and assembles the result.
- Start/busy/done handshake toward the requester.
- Used where area matters more than add latency; the full_adder cell is the only arithmetic resource.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse/level; sampled only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high while bits are being computed
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result; held until next completion
- cout  output  1  registered carry-out; held with sum

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high; all state changes on rising `clk`.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0; operand shift regs, carry reg and counter also cleared. Reset wins over every other event, including mid-computation. No partial result is ever published after reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge -> capture a, b into shift regs; carry reg <= cin; cnt <= 0; go to RUN.
  - start=0 -> stay in IDLE.
- RUN (busy=1):
  - Each cycle the full_adder cell sees a_sh[0], b_sh[0] and the carry reg.
  - At the edge: s is shifted into the MSB of the result shift reg (shift right); carry reg <= c_out; a_sh and b_sh shift right; cnt++.
  - When cnt==WIDTH-1 at the edge: go to DONE; sum <= completed result; cout <= final c_out.
- DONE (busy=0, done=1 for exactly this cycle): unconditional return to IDLE. start is ignored in DONE.
- Latency: start accepted at edge 0 -> RUN for cycles 1..WIDTH -> done high in cycle WIDTH+1. Minimum start-to-start spacing is WIDTH+2 cycles.
- Output stability: sum and cout change only on entry to DONE (or on reset). While busy they keep the previous result.
- Input handling:
  - start while busy or done is ignored; nothing is queued.
  - a, b and cin are don't-care outside the capture edge.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1). No other wrap cases.
- Counter never exceeds WIDTH-1. The only valid encodings are IDLE, RUN and DONE; any illegal encoding returns to IDLE next cycle.

Optional Feature:
- Macro: SERIAL_ADD_OVERFLOW_EN.
- Defined:
  - Adds output port `ovf` (1 bit), registered, reset 0, updated together with sum.
  - ovf = signed two's-complement overflow = carry into MSB XOR carry out of MSB. The carry into the MSB is the carry reg value during the last RUN cycle.
- Undefined:
  - Port `ovf` and its logic do not exist.
  - All other behaviour is identical.

Test Plan:
- Reset, then WIDTH=8, a=0x00, b=0x00, cin=0, start pulse -> busy high cycles 1..8, done pulse in cycle 9, sum=0x00, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, done at start+9. sum keeps its prior value until the done cycle.
- a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Then a=0x3C, b=0x0F, cin=0 -> sum=0x4B, cout=0.
- start held high continuously with a=0x12, b=0x34 -> results at cycles 9, 19, 29 (period 10). start during busy/done is ignored. Operands changed mid-RUN have no effect on sum=0x46.
- Assert rst in cycle 4 of RUN -> next cycle busy=0, done=0, sum=0, cout=0, state IDLE. A following start with a=0x01, b=0x01 -> sum=0x02 after 9 cycles.
- With SERIAL_ADD_OVERFLOW_EN defined:
  - a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
  - a=0xFF, b=0x01 -> ovf=0.
  - a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
